uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   Buffered 8-bit UART transmitter; consumes tx_data/tx_start from the control block, returns tx_busy.
//   Small byte FIFO feeds an FSM that drives 8N1 frames (optional parity) onto the serial line.
//   Sits between control logic and the board TXD pin, on the same clock domain.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock in Hz
//   BAUD        115200      line rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer, truncated; 434)
//   FIFO_DEPTH  4           byte FIFO entries; power of 2, >=2
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst          in   1  synchronous reset, active-low
//   tx_data      in   8  byte to send; sampled when tx_start=1
//   tx_start     in   1  single-cycle write strobe
//   tx_busy      out  1  FIFO full; tx_start is dropped while high
//   tx_overflow  out  1  one-cycle pulse: tx_start while full, byte discarded
//   tx_idle      out  1  FSM in IDLE and FIFO empty
//   uart_txd     out  1  serial line, idle high
// BEHAVIOUR
//   Reset (rst=0 at rising edge): uart_txd=1, tx_busy=0, tx_overflow=0, tx_idle=1,
//     FIFO pointers/count=0, FSM=IDLE, baud counter=0, bit index=0. Mid-frame reset aborts the frame;
//     line is high from the next edge; buffered bytes are discarded.
//   All outputs registered. tx_busy = (count==FIFO_DEPTH).
//   Push: at edge with tx_start=1 and tx_busy=0, tx_data written at wr_ptr; pointers wrap mod FIFO_DEPTH.
//   Full test uses count before the edge; a same-edge pop does not free space for a same-edge push.
//   Push and pop on the same edge: count unchanged, both pointers advance.
//   FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
//     IDLE : if count!=0, pop into shift reg, -> START. Else stay, uart_txd=1.
//     START: uart_txd=0 for CLKS_PER_BIT cycles -> DATA.
//     DATA : LSB first, bit index 0..7, each CLKS_PER_BIT cycles; after bit 7 -> PARITY or STOP.
//     PARITY: uart_txd = ^byte (even parity) for CLKS_PER_BIT cycles -> STOP.
//     STOP : uart_txd=1 for CLKS_PER_BIT cycles; at end, if count!=0 pop and -> START (no idle gap),
//            else -> IDLE.
//   Baud counter runs 0..CLKS_PER_BIT-1, cleared on every bit/state transition.
//   Latency: tx_start at edge N into empty FIFO with FSM IDLE -> pop at edge N+1 -> uart_txd low after N+2.
//   Frame = 10*CLKS_PER_BIT cycles (11 with parity). tx_idle falls after the push edge, rises on IDLE entry
//     with empty FIFO.
//   Capacity: FIFO_DEPTH queued + 1 in shift register.
// CONFIGURATION
//   UART_TX_PARITY_EN defined   : PARITY state inserted after DATA, even parity, 11-bit frame.
//   UART_TX_PARITY_EN undefined : PARITY state and logic absent; 8N1, 10-bit frame.
// TESTING  (CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10, FIFO_DEPTH=4)
//   Single 0x55 -> uart_txd 0 x10, then 1,0,1,0,1,0,1,0 x10 each, stop 1 x10; tx_idle=1 100 cycles after
//     the start bit begins.
//   Six consecutive tx_start, 0x10..0x15, ignoring tx_busy -> tx_busy=1 after 5th edge; 0x15 dropped with
//     one-cycle tx_overflow; 0x10..0x14 sent back-to-back, no gaps between stop and start bits.
//   Parity build: 0x07 -> parity bit 1; 0x03 -> parity bit 0; stop bit follows, 110-cycle frames.
//   rst=0 for one edge during DATA bit 3 of 0x0F with 2 bytes queued -> uart_txd=1 next cycle, tx_idle=1,
//     tx_busy=0; no further frames.
//   tx_start 0xA5 on the final STOP cycle of a frame with empty FIFO -> IDLE entered, then pop next edge;
//     start bit of 0xA5 begins 2 cycles after the write edge; byte not lost.
//   Reset check: hold rst=0 for 3 cycles with tx_start=1 -> uart_txd=1, tx_busy=0, tx_overflow=0,
//     tx_idle=1 throughout.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8-bit UART transmitter.
// A small byte FIFO accepts writes from the control block. A two-process FSM
// pops bytes and drives frames LSB-first onto uart_txd, which idles high.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is inserted after the data bits, giving 11-bit frames. When it is
// undefined, the transmitter sends 8N1 frames of 10 bits.
// Every output is registered. uart_txd follows the FSM state with one cycle of
// lag, so a byte written into an empty, idle transmitter starts its start bit
// two edges after the write.
`timescale 1ns/1ps

module uart_tx_buffered #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       tx_idle,
  output logic       uart_txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNTF_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNTF_W-1:0] FIFO_FULL = CNTF_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic                line_d;
  logic                pop;
  logic                baud_end;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNTF_W-1:0]   count_q, count_d;
  logic [7:0]          shift_q;
  logic                full;
  logic                push;
  logic                tx_idle_d;

  // The full test uses the count from before the edge, so a pop on the same
  // edge never makes room for a push on that edge.
  assign full     = (count_q == FIFO_FULL);
  assign push     = tx_start && !full;
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, baud/bit counters, pop request and next line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    line_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        line_d = shift_q[bit_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        line_d = even_parity(shift_q);
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        line_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          // A queued byte goes straight into the next start bit, so no idle gap appears.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // FIFO occupancy for the next cycle; a push and a pop on the same edge cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    tx_idle_d = (state_d == ST_IDLE) && (count_d == '0);
  end

  // Control state and registered outputs, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_overflow <= 1'b0;
      tx_idle     <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      count_q     <= count_d;
      uart_txd    <= line_d;
      tx_busy     <= (count_d == FIFO_FULL);
      tx_overflow <= tx_start && full;
      tx_idle     <= tx_idle_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Byte storage and the shift register; pointer reset alone discards contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
    if (pop)  shift_q     <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: CLKS_PER_BIT=10, FIFO_DEPTH=4.
// Accepted bytes are queued as expectations when they are written. A line
// decoder then rebuilds each frame from uart_txd and compares it with the queue.
`timescale 1ns/1ps

module tb_uart_tx_buffered;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_overflow, tx_idle, uart_txd;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_overflow(tx_overflow),
    .tx_idle    (tx_idle),
    .uart_txd   (uart_txd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Polls at negedges until the line goes low; the caller sits on a negedge.
  task automatic wait_start(input int max_wait, output bit found);
    found = 1'b0;
    for (int w = 0; w < max_wait; w++) begin
      if (uart_txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check("start_timeout", 32'd1, 32'd0);
  endtask

  // Decodes one frame: each bit must hold for CPB cycles; returns on the last stop-bit cycle.
  task automatic recv_frame(input string tag);
    logic [10:0] slot;
    logic [7:0]  d;
    bit          stable;
    bit          found;
    wait_start(400, found);
    if (found) begin
      slot   = '1;
      stable = 1'b1;
      for (int k = 0; k < FRAME_BITS; k++) begin
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (c == 0) slot[k] = uart_txd;
          else if (uart_txd !== slot[k]) stable = 1'b0;
        end
      end
      d = slot[8:1];
      check({tag, "_start"},  32'(slot[0]), 32'd0);
      check({tag, "_stable"}, 32'(stable), 32'd1);
`ifdef UART_TX_PARITY_EN
      check({tag, "_parity"}, 32'(slot[9]), 32'(^d));
`endif
      check({tag, "_stop"}, 32'(slot[FRAME_BITS-1]), 32'd1);
      check({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check({tag, "_data"}, 32'(d), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit any_low;

    // Reset held for three edges with tx_start asserted
    rst      = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_txd",  32'(uart_txd),    32'd1);
      check("rst_busy", 32'(tx_busy),     32'd0);
      check("rst_ovf",  32'(tx_overflow), 32'd0);
      check("rst_idle", 32'(tx_idle),     32'd1);
    end
    rst      = 1'b1;
    tx_start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(tx_idle), 32'd1);

    // Single 0x55: latency and framing
    tx_data  = 8'h55;
    tx_start = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);
    tx_start = 1'b0;
    check("lat_idle_fall", 32'(tx_idle),  32'd0);
    check("lat_txd_n",     32'(uart_txd), 32'd1);
    @(negedge clk);
    check("lat_txd_n1",    32'(uart_txd), 32'd1);
    @(negedge clk);
    check("lat_txd_n2",    32'(uart_txd), 32'd0);
    check("busy_idle_mid", 32'(tx_idle),  32'd0);
    recv_frame("b55");
    @(negedge clk);
    check("b55_idle_after", 32'(tx_idle),  32'd1);
    check("b55_line_high",  32'(uart_txd), 32'd1);

    // Six writes ignoring tx_busy; the sixth is dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          tx_data  = 8'(8'h10 + i);
          tx_start = 1'b1;
          if (i < 5) exp_q.push_back(8'(8'h10 + i));
          @(negedge clk);
          if (i == 3) check("burst_busy_e4", 32'(tx_busy), 32'd0);
          if (i == 4) begin
            check("burst_busy_e5", 32'(tx_busy),     32'd1);
            check("burst_ovf_e5",  32'(tx_overflow), 32'd0);
          end
          if (i == 5) check("burst_ovf_e6", 32'(tx_overflow), 32'd1);
        end
        tx_start = 1'b0;
        @(negedge clk);
        check("burst_ovf_e7",  32'(tx_overflow), 32'd0);
        check("burst_busy_e7", 32'(tx_busy),     32'd1);
      end
      begin
        for (int f = 0; f < 5; f++) begin
          recv_frame("burst");
          if (f < 4) begin
            @(negedge clk);
            check("burst_gap", 32'(uart_txd), 32'd0);
          end
        end
      end
    join
    @(negedge clk);
    check("burst_idle_after", 32'(tx_idle), 32'd1);

    // Parity-sensitive bytes
    send(8'h07);
    recv_frame("b07");
    send(8'h03);
    recv_frame("b03");
    @(negedge clk);

    // Write landing on the final STOP cycle of a frame with an empty FIFO
    send(8'h3C);
    exp_q.push_back(8'hA5);
    fork
      begin
        wait_start(50, found);
        if (found) begin
          repeat (CPB * FRAME_BITS - 2) @(negedge clk);
          tx_data  = 8'hA5;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          check("late_idle_low", 32'(tx_idle), 32'd0);
        end
      end
      begin
        recv_frame("b3c");
        @(negedge clk);
        check("late_gap_high",  32'(uart_txd), 32'd1);
        @(negedge clk);
        check("late_start_low", 32'(uart_txd), 32'd0);
        recv_frame("ba5");
      end
    join
    @(negedge clk);
    check("late_idle_after", 32'(tx_idle), 32'd1);

    // Reset during DATA bit 3 of 0x0F with two bytes queued
    for (int i = 0; i < 3; i++) begin
      tx_data  = (i == 0) ? 8'h0F : 8'(8'h20 + i);
      tx_start = 1'b1;
      @(negedge clk);
    end
    tx_start = 1'b0;
    wait_start(50, found);
    if (found) begin
      repeat (44) @(negedge clk);
      check("pre_rst_bit3", 32'(uart_txd), 32'd1);
      check("pre_rst_idle", 32'(tx_idle),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("mid_rst_txd",  32'(uart_txd), 32'd1);
      check("mid_rst_idle", 32'(tx_idle),  32'd1);
      check("mid_rst_busy", 32'(tx_busy),  32'd0);
      any_low = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (uart_txd !== 1'b1) any_low = 1'b1;
      end
      check("post_rst_quiet", 32'(any_low), 32'd0);
      check("post_rst_idle2", 32'(tx_idle), 32'd1);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
